score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Judges lane button presses against notes in the hit zone, accumulating score, combo and multiplier for the play screen.
- Sits directly upstream of the screen generator, which consumes `score` (17-bit binary, 0..99999) for the five-digit SCORE display.
- Emits per-lane hit-flash levels for the hit-zone highlight and `note_consumed` pulses back to the note engine, which then retires hit notes.

Parameters:
- POINTS_PER_HIT, 10, base points per hit before multiplier
- SCORE_MAX, 99999, saturation value of `score` (fits 17 bits)
- COMBO_STEP, 10, consecutive hits per multiplier step
- MULT_MAX, 4, multiplier ceiling
- COMBO_MAX, 99, combo saturation value
- FLASH_FRAMES, 8, frames `hit_flash` stays high after a hit

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  reset; synchronous, active-high
- clear  in  1  synchronous song-start clear; one-cycle pulse
- frame_tick  in  1  one-cycle pulse per frame, asserted at vertical blank
- btn  in  5  raw lane buttons, asynchronous; bit0 = green, then yellow, blue, orange, white
- note_in_zone  in  5  level; lane i has a note overlapping the hit zone
- note_passed  in  5  one-cycle pulse; lane i note left the hit zone unhit
- score  out  17  registered accumulated score
- combo  out  7  registered consecutive-hit count
- multiplier  out  3  `min(1 + combo/COMBO_STEP, MULT_MAX)`, combinational from the combo register
- hit_flash  out  5  lane i recently hit
- note_consumed  out  5  registered one-cycle pulse; note on lane i was hit

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named `clk` and `reset`.
- Reset values: `score`=0, `combo`=0, `multiplier`=1, `hit_flash`=0, `note_consumed`=0, synchronizer and edge flops=0.
- Input conditioning: `btn` passes through a 2-flop synchronizer, then a previous-value flop.
  - `press[i] = sync2[i] & ~prev[i]`.
  - Holding a button yields exactly one press.
- Latency: `btn[i]` first sampled high at edge k → `score`, `combo` and `note_consumed` change at edge k+2.
  - `note_in_zone` and `note_passed` are sampled at that same edge k+2.
- Per-cycle judging, per lane i:
  - `hit[i] = press[i] & note_in_zone[i]`.
  - `miss[i] = (press[i] & ~note_in_zone[i]) | (note_passed[i] & ~hit[i])`.
  - Hit wins over `note_passed` on the same lane in the same cycle.
- Score update:
  - `add = popcount(hit) * POINTS_PER_HIT * multiplier`.
  - `multiplier` is the value before this cycle's combo update.
  - The sum is computed at least 18 bits wide: `score <= min(score + add, SCORE_MAX)`; `score` holds at `SCORE_MAX` once reached.
- Combo update:
  - If `|miss`: `combo <= 0` (misses win over simultaneous hits; those hits still score).
  - Else: `combo <= min(combo + popcount(hit), COMBO_MAX)`.
- `note_consumed <= hit`; zero in every cycle with no hit.
- Flash counters, one per lane, width ≥ clog2(FLASH_FRAMES+1):
  - On `hit[i]`: load FLASH_FRAMES. Reload wins over a coincident `frame_tick`.
  - Else on `frame_tick` with a nonzero counter: decrement.
  - `hit_flash[i] = (cnt[i] != 0)`.
- `clear`:
  - Next edge: `score`, `combo`, flash counters and `note_consumed` go to 0.
  - Sync and edge flops are unaffected.
  - `clear` overrides any hit or miss in that cycle.
- `reset` mid-play: identical to the reset values above on the next edge.
- No other state is kept; notes are never buffered.

Test Plan:
1. Reset, hold `note_in_zone`=00001, pulse `btn[0]` high for 20 cycles → at edge k+2: `score`=10, `combo`=1, `multiplier`=1, `note_consumed`=00001 for exactly 1 cycle, `hit_flash[0]`=1. Holding the button produces no further hits.
2. Ten separated lane-2 hits with `note_in_zone[2]`=1 → `combo`=10, `multiplier`=2, `score`=100. An 11th hit → `score`=120, `combo`=11.
3. From `combo`=5, press lane 3 with `note_in_zone`=0 → `combo`=0, `score` unchanged, `note_consumed`=0.
4. Drive `combo` to 39 (`multiplier`=4). Then in one cycle: hits on lanes 0, 2, 4 plus `note_passed[1]` → `score` +120, `combo`=0, `note_consumed`=10101. Repeating without `note_passed` → `combo`=42.
5. With SCORE_MAX=50: six single hits → `score` sequence 10, 20, 30, 40, 50, 50. Hit 6 saturates and does not wrap.
6. Hit lane 4, then issue 8 `frame_tick` pulses → `hit_flash[4]` falls on the 8th tick. A second hit after 4 ticks keeps it high for 8 more ticks. `clear` mid-flash → `hit_flash`=0, `score`=0, `combo`=0 on the next edge.

Source files
------------

// File: rtl/score_keeper.sv
// Judges lane presses against hit-zone notes and keeps score, combo, multiplier
// and per-lane hit-flash timers for the play screen.
module score_keeper #(
  parameter int POINTS_PER_HIT = 10,
  parameter int SCORE_MAX      = 99999,
  parameter int COMBO_STEP     = 10,
  parameter int MULT_MAX       = 4,
  parameter int COMBO_MAX      = 99,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        frame_tick,
  input  logic [4:0]  btn,
  input  logic [4:0]  note_in_zone,
  input  logic [4:0]  note_passed,
  output logic [16:0] score,
  output logic [6:0]  combo,
  output logic [2:0]  multiplier,
  output logic [4:0]  hit_flash,
  output logic [4:0]  note_consumed
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic [4:0]    btn_meta;
  logic [4:0]    btn_sync;
  logic [4:0]    btn_prev;
  logic [4:0]    press;
  logic [4:0]    hit;
  logic [4:0]    miss;
  logic [2:0]    hit_count;
  logic [6:0]    combo_steps;
  logic [17:0]   add;
  logic [17:0]   score_sum;
  logic [16:0]   score_next;
  logic [7:0]    combo_sum;
  logic [6:0]    combo_next;
  logic [FW-1:0] flash_cnt [5];

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // Buttons are asynchronous: two-flop synchronizer, then an edge detector so
  // a held button counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign press     = btn_sync & ~btn_prev;
  assign hit       = press & note_in_zone;
  assign miss      = (press & ~note_in_zone) | (note_passed & ~hit);
  assign hit_count = popcount5(hit);

  assign combo_steps = combo / 7'(COMBO_STEP);

  always_comb begin
    multiplier = 3'd1;
    if (combo_steps >= 7'(MULT_MAX - 1)) multiplier = 3'(MULT_MAX);
    else                                 multiplier = 3'(combo_steps) + 3'd1;
  end

  // Sum is one bit wider than score so saturation is detected before any wrap.
  always_comb begin
    add        = 18'(hit_count) * 18'(POINTS_PER_HIT) * 18'(multiplier);
    score_sum  = {1'b0, score} + add;
    score_next = score_sum[16:0];
    if (score_sum > 18'(SCORE_MAX)) score_next = 17'(SCORE_MAX);
  end

  always_comb begin
    combo_sum  = {1'b0, combo} + 8'(hit_count);
    combo_next = combo_sum[6:0];
    if (|miss)                            combo_next = 7'd0;
    else if (combo_sum > 8'(COMBO_MAX))   combo_next = 7'(COMBO_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score         <= '0;
      combo         <= '0;
      note_consumed <= '0;
    end else begin
      score         <= score_next;
      combo         <= combo_next;
      note_consumed <= hit;
    end
  end

  // Flash timers count frames down to zero; a new hit reloads even on a tick.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset || clear)
        flash_cnt[i] <= '0;
      else if (hit[i])
        flash_cnt[i] <= FW'(FLASH_FRAMES);
      else if (frame_tick && (flash_cnt[i] != '0))
        flash_cnt[i] <= flash_cnt[i] - 1'b1;
    end
  end

  always_comb begin
    hit_flash = '0;
    for (int i = 0; i < 5; i++) hit_flash[i] = (flash_cnt[i] != '0);
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a frame-level reference model predicts each
// edge's outputs; a monitor compares two DUTs (default and SCORE_MAX=50).
module tb_score_keeper;

  localparam int PTS       = 10;
  localparam int SMAX_A    = 99999;
  localparam int SMAX_B    = 50;
  localparam int STEP      = 10;
  localparam int MMAX      = 4;
  localparam int CMAX      = 99;
  localparam int FLASH     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        frame_tick = 1'b0;
  logic [4:0]  btn = '0;
  logic [4:0]  note_in_zone = '0;
  logic [4:0]  note_passed = '0;

  logic [16:0] score_a, score_b;
  logic [6:0]  combo_a, combo_b;
  logic [2:0]  mult_a, mult_b;
  logic [4:0]  flash_a, flash_b;
  logic [4:0]  nc_a, nc_b;

  score_keeper dut (
    .clk(clk), .reset(reset), .clear(clear), .frame_tick(frame_tick),
    .btn(btn), .note_in_zone(note_in_zone), .note_passed(note_passed),
    .score(score_a), .combo(combo_a), .multiplier(mult_a),
    .hit_flash(flash_a), .note_consumed(nc_a)
  );

  score_keeper #(.SCORE_MAX(SMAX_B)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .frame_tick(frame_tick),
    .btn(btn), .note_in_zone(note_in_zone), .note_passed(note_passed),
    .score(score_b), .combo(combo_b), .multiplier(mult_b),
    .hit_flash(flash_b), .note_consumed(nc_b)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         tag;
    int         score_a;
    int         score_b;
    int         combo;
    int         mult;
    logic [4:0] flash;
    logic [4:0] nc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: scores, combo, frames left per lane, and btn as sampled
  // at each recent edge (newest last).
  int         m_score_a = 0;
  int         m_score_b = 0;
  int         m_combo = 0;
  int         m_flash[5];
  logic [4:0] m_nc = '0;
  logic [4:0] hist[$];

  function automatic int mult_of(input int c);
    int m;
    m = 1 + c / STEP;
    return (m > MMAX) ? MMAX : m;
  endfunction

  task automatic model_edge(input logic r, input logic clr, input logic ft,
                            input logic [4:0] b, input logic [4:0] nz, input logic [4:0] np);
    logic [4:0] press, hit, miss;
    int add;
    if (r) begin
      m_score_a = 0; m_score_b = 0; m_combo = 0; m_nc = '0;
      for (int i = 0; i < 5; i++) m_flash[i] = 0;
      hist.delete();
      repeat (3) hist.push_back(5'd0);
      return;
    end
    // A press is judged two edges after the button is first sampled high.
    press = hist[hist.size()-2] & ~hist[hist.size()-3];
    hit   = press & nz;
    miss  = (press & ~nz) | (np & ~hit);
    if (clr) begin
      m_score_a = 0; m_score_b = 0; m_combo = 0; m_nc = '0;
      for (int i = 0; i < 5; i++) m_flash[i] = 0;
    end else begin
      add = $countones(hit) * PTS * mult_of(m_combo);
      m_score_a = (m_score_a + add > SMAX_A) ? SMAX_A : m_score_a + add;
      m_score_b = (m_score_b + add > SMAX_B) ? SMAX_B : m_score_b + add;
      if (miss != 0) m_combo = 0;
      else m_combo = (m_combo + $countones(hit) > CMAX) ? CMAX : m_combo + $countones(hit);
      m_nc = hit;
      for (int i = 0; i < 5; i++) begin
        if (hit[i]) m_flash[i] = FLASH;
        else if (ft && m_flash[i] > 0) m_flash[i] = m_flash[i] - 1;
      end
    end
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic step(input logic r, input logic clr, input logic ft,
                      input logic [4:0] b, input logic [4:0] nz, input logic [4:0] np);
    exp_t e;
    reset = r; clear = clr; frame_tick = ft;
    btn = b; note_in_zone = nz; note_passed = np;
    model_edge(r, clr, ft, b, nz, np);
    e.tag = edge_cnt + 1;
    e.score_a = m_score_a;
    e.score_b = m_score_b;
    e.combo   = m_combo;
    e.mult    = mult_of(m_combo);
    for (int i = 0; i < 5; i++) e.flash[i] = (m_flash[i] != 0);
    e.nc = m_nc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] nz);
    repeat (n) step(1'b0, 1'b0, 1'b0, 5'd0, nz, 5'd0);
  endtask

  // One-cycle button pulse; np lands on the edge where that press is judged.
  task automatic tap(input logic [4:0] lanes, input logic [4:0] nz, input logic [4:0] np);
    step(1'b0, 1'b0, 1'b0, lanes, nz, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0,  nz, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0,  nz, np);
    step(1'b0, 1'b0, 1'b0, 5'd0,  nz, 5'd0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v, input int tag);
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, tag, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
        e = sb.pop_front();
        n_vec++;
        check("score",        int'(score_a), e.score_a, e.tag);
        check("score_sat",    int'(score_b), e.score_b, e.tag);
        check("combo",        int'(combo_a), e.combo,   e.tag);
        check("combo_sat",    int'(combo_b), e.combo,   e.tag);
        check("multiplier",   int'(mult_a),  e.mult,    e.tag);
        check("mult_sat",     int'(mult_b),  e.mult,    e.tag);
        check("hit_flash",    int'(flash_a), int'(e.flash), e.tag);
        check("hit_flash_sat",int'(flash_b), int'(e.flash), e.tag);
        check("consumed",     int'(nc_a),    int'(e.nc), e.tag);
        check("consumed_sat", int'(nc_b),    int'(e.nc), e.tag);
      end
    end
  end

  initial begin : driver
    logic [4:0] b, nz, np;
    int mode;
    for (int i = 0; i < 5; i++) m_flash[i] = 0;
    repeat (3) hist.push_back(5'd0);

    // Reset, then a held green button yields a single hit.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 5'b00001, 5'b00001, 5'd0);
    idle(4, 5'b00001);

    // Ten lane-2 hits reach multiplier 2, the eleventh scores 20.
    do_clear();
    repeat (11) tap(5'b00100, 5'b00100, 5'd0);

    // Press with no note breaks a combo of 5.
    do_clear();
    repeat (5) tap(5'b01000, 5'b01000, 5'd0);
    tap(5'b01000, 5'd0, 5'd0);

    // Combo 39, triple hit with a passed note, then the same without it.
    do_clear();
    repeat (39) tap(5'b00001, 5'b00001, 5'd0);
    tap(5'b10101, 5'b10101, 5'b00010);
    do_clear();
    repeat (39) tap(5'b00001, 5'b00001, 5'd0);
    tap(5'b10101, 5'b10101, 5'd0);

    // Saturation (second DUT caps at 50).
    do_clear();
    repeat (6) tap(5'b00010, 5'b00010, 5'd0);

    // Flash timing, reload, reload coincident with a tick, clear mid-flash.
    do_clear();
    tap(5'b10000, 5'b10000, 5'd0);
    tick(8);
    tap(5'b10000, 5'b10000, 5'd0);
    tick(4);
    tap(5'b10000, 5'b10000, 5'd0);
    tick(8);
    step(1'b0, 1'b0, 1'b0, 5'b10000, 5'b10000, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0,     5'b10000, 5'd0);
    step(1'b0, 1'b0, 1'b1, 5'd0,     5'b10000, 5'd0);
    tick(2);
    tap(5'b00011, 5'b00011, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'b00100, 5'b00100, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0,     5'b00100, 5'd0);
    step(1'b0, 1'b1, 1'b0, 5'd0,     5'b00100, 5'b01000);
    idle(3, 5'd0);

    // Randomised play: alternating phases of clean runs and noisy judging.
    b = '0;
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) mode = $urandom_range(0, 1);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 2) == 0) b[i] = ~b[i];
      if (mode == 0) begin
        nz = 5'b11111;
        np = 5'd0;
      end else begin
        nz = 5'($urandom);
        np = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      end
      step(($urandom_range(0, 1499) == 0), ($urandom_range(0, 399) == 0),
           ($urandom_range(0, 3) == 0), b, nz, np);
    end
    idle(4, 5'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
